prio_encoder_q: RTL

- Parametrised, registered N-to-log2(N) priority encoder with request latching.
- Request bits are captured into a pending vector.
- Pending requests are issued one at a time as binary indices over a valid/ready output handshake.
- Supports fixed-priority or round-robin selection; used wherever several event sources must be funnelled into a single encoded index stream.

---
 rtl/prio_enc_pkg.sv | 16 +
 rtl/prio_pick.sv | 57 +++++
 rtl/prio_encoder_q.sv | 95 +++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and sizing helpers for the registered priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    PE_FIXED = 1'b0,
    PE_RR    = 1'b1
  } pe_mode_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: rotate the candidates so the search starts
// just after ptr, take the lowest set bit, then map back to a line index.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int       N    = 8,
  parameter int       W    = clog2_min1(N),
  parameter pe_mode_t MODE = PE_FIXED
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         any
);

  logic [W-1:0] shift;
  logic [N-1:0] rot;
  logic [W-1:0] first;
  logic [W:0]   sum;

  // Out-of-range pointers also fall back to a search starting at line 0.
  always_comb begin
    shift = '0;
    if (MODE == PE_RR && ptr < W'(N - 1))
      shift = ptr + 1'b1;
  end

  // rot[i] = cand[(i + shift) mod N]
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      always_comb begin
        int src;
        src = gi + int'(shift);
        if (src >= N)
          src = src - N;
        rot[gi] = cand[src];
      end
    end
  endgenerate

  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i])
        first = W'(i);
    end
  end

  always_comb begin
    sum = {1'b0, first} + {1'b0, shift};
    if (sum >= (W+1)'(N))
      sum = sum - (W+1)'(N);
    win = sum[W-1:0];
    any = |cand;
  end

endmodule

// File: rtl/prio_encoder_q.sv
// Registered N-to-log2(N) priority encoder: requests latch into a pending
// vector and are issued one index at a time over a valid/ready handshake.
module prio_encoder_q
  import prio_enc_pkg::*;
#(
  parameter int       N    = 8,
  parameter int       W    = clog2_min1(N),
  parameter pe_mode_t MODE = PE_FIXED
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_index,
  output logic [N-1:0] pending,
  output logic         dup
);

  logic [N-1:0] pending_reg, pending_next;
  logic         valid_reg, valid_next;
  logic [W-1:0] index_reg, index_next;
  logic [W-1:0] ptr_reg, ptr_next;
  logic         dup_reg, dup_next;

  logic [N-1:0] cand;
  logic [N-1:0] win_onehot;
  logic [W-1:0] win;
  logic         any;
  logic         load;

  assign cand = pending_reg | req;
  assign load = !valid_reg || out_ready;

  prio_pick #(
    .N    (N),
    .W    (W),
    .MODE (MODE)
  ) u_pick (
    .cand (cand),
    .ptr  (ptr_reg),
    .win  (win),
    .any  (any)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign win_onehot[gi] = (win == W'(gi));
    end
  endgenerate

  // The in-flight grant is not part of pending, so a request for the same
  // line while stalled is a fresh event rather than a duplicate.
  always_comb begin
    pending_next = cand;
    valid_next   = valid_reg;
    index_next   = index_reg;
    ptr_next     = ptr_reg;
    dup_next     = |(req & pending_reg);
    if (load) begin
      if (any) begin
        valid_next   = 1'b1;
        index_next   = win;
        pending_next = cand & ~win_onehot;
        if (MODE == PE_RR)
          ptr_next = win;
      end else begin
        valid_next   = 1'b0;
        pending_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      index_reg   <= '0;
      ptr_reg     <= W'(N - 1);
      dup_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      valid_reg   <= valid_next;
      index_reg   <= index_next;
      ptr_reg     <= ptr_next;
      dup_reg     <= dup_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_index = index_reg;
  assign pending   = pending_reg;
  assign dup       = dup_reg;

endmodule
